seq_div_ctrl: RTL and testbench

Iterative unsigned integer divider controller that sequences the existing single-step restoring-division stage `combinational_div` over multiple clock cycles.
- Accepts a dividend/divisor pair through a start/busy/done handshake.
- Instantiates UNROLL chained copies of the step stage and iterates SIZE/UNROLL cycles.
- Returns quotient and remainder.
- Serves as the mantissa-division engine for the FP divider.

---
 rtl/div_pkg.sv | 17 +
 rtl/combinational_div.sv | 36 +++
 rtl/seq_div_ctrl.sv | 151 +++++++++++++++
 tb/tb_seq_div_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider: state encoding,
// default operand width and the quotient returned on divide-by-zero.
package div_pkg;

    localparam int DIV_SIZE     = 32;
    localparam int DIV_MAX_SIZE = 64;

    // Sliced down to SIZE bits by the controller; supports widths up to 64.
    localparam logic [DIV_MAX_SIZE-1:0] DBZ_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } div_state_e;

endpackage

// File: rtl/combinational_div.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and append the quotient bit.
module combinational_div #(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] N,
    input  logic [SIZE-1:0] D,
    input  logic [SIZE-1:0] R,
    input  logic [SIZE-1:0] Q,
    input  logic [SIZE-1:0] I,
    output logic [SIZE-1:0] NO,
    output logic [SIZE-1:0] QO,
    output logic [SIZE-1:0] RO,
    output logic [SIZE-1:0] IO
);

    logic [SIZE-1:0] t;
    logic            unused_r_msb;

    // The remainder MSB is shifted out; it is always zero while D < 2**(SIZE-1).
    assign unused_r_msb = R[SIZE-1];
    assign t            = {R[SIZE-2:0], N[SIZE-1]};
    assign NO           = N << 1;
    assign IO           = I + SIZE'(1);

    always_comb begin
        if (t >= D) begin
            RO = t - D;
            QO = {Q[SIZE-2:0], 1'b1};
        end else begin
            RO = t;
            QO = {Q[SIZE-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_div_ctrl.sv
// Multi-cycle unsigned divider: runs UNROLL chained restoring steps per clock
// behind a start/busy/done handshake, with abort and divide-by-zero handling.
module seq_div_ctrl
    import div_pkg::*;
#(
    parameter int SIZE   = DIV_SIZE,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] dividend,
    input  logic [SIZE-1:0] divisor,
    input  logic            abort,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] quotient,
    output logic [SIZE-1:0] remainder,
    output logic            div_by_zero
);

    localparam logic [SIZE-1:0] LAST_ITER = SIZE'(SIZE);

    div_state_e      state_q, state_d;
    logic [SIZE-1:0] n_q, n_d;
    logic [SIZE-1:0] d_q, d_d;
    logic [SIZE-1:0] r_q, r_d;
    logic [SIZE-1:0] q_q, q_d;
    logic [SIZE-1:0] i_q, i_d;
    logic [SIZE-1:0] quotient_q, quotient_d;
    logic [SIZE-1:0] remainder_q, remainder_d;
    logic            dbz_q, dbz_d;
    logic            done_q, done_d;

    // Index 0 is the registered state; index k+1 is the output of step k.
    logic [SIZE-1:0] n_c [UNROLL+1];
    logic [SIZE-1:0] r_c [UNROLL+1];
    logic [SIZE-1:0] q_c [UNROLL+1];
    logic [SIZE-1:0] i_c [UNROLL+1];

    assign n_c[0] = n_q;
    assign r_c[0] = r_q;
    assign q_c[0] = q_q;
    assign i_c[0] = i_q;

    for (genvar k = 0; k < UNROLL; k++) begin : g_step
        combinational_div #(.SIZE(SIZE)) u_step (
            .N  (n_c[k]),
            .D  (d_q),
            .R  (r_c[k]),
            .Q  (q_c[k]),
            .I  (i_c[k]),
            .NO (n_c[k+1]),
            .QO (q_c[k+1]),
            .RO (r_c[k+1]),
            .IO (i_c[k+1])
        );
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        d_d         = d_q;
        r_d         = r_q;
        q_d         = q_q;
        i_d         = i_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    n_d = dividend;
                    d_d = divisor;
                    r_d = '0;
                    q_d = '0;
                    i_d = '0;
                    if (divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = DBZ_QUOTIENT[SIZE-1:0];
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        done_d      = 1'b1;
                    end else begin
                        state_d = COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    n_d = n_c[UNROLL];
                    r_d = r_c[UNROLL];
                    q_d = q_c[UNROLL];
                    i_d = i_c[UNROLL];
                    if (i_c[UNROLL] == LAST_ITER) begin
                        state_d     = DONE;
                        quotient_d  = q_c[UNROLL];
                        remainder_d = r_c[UNROLL];
                        dbz_d       = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            n_q         <= '0;
            d_q         <= '0;
            r_q         <= '0;
            q_q         <= '0;
            i_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            d_q         <= d_d;
            r_q         <= r_d;
            q_q         <= q_d;
            i_q         <= i_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
        end
    end

    assign ready       = (state_q == IDLE);
    assign busy        = (state_q == COMPUTE);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_ctrl.sv
// Directed bench for seq_div_ctrl: a UNROLL=1 instance for protocol and
// boundary cases, and a UNROLL=4 instance for latency and random operands.
module tb_seq_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start = 1'b0, abort = 1'b0;
    logic [31:0] dividend = '0, divisor = '0;
    logic        ready, busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    logic        start4 = 1'b0, abort4 = 1'b0;
    logic [31:0] dividend4 = '0, divisor4 = '0;
    logic        ready4, busy4, done4, div_by_zero4;
    logic [31:0] quotient4, remainder4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_div_ctrl #(.SIZE(32), .UNROLL(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .abort       (abort),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    seq_div_ctrl #(.SIZE(32), .UNROLL(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .start       (start4),
        .dividend    (dividend4),
        .divisor     (divisor4),
        .abort       (abort4),
        .ready       (ready4),
        .busy        (busy4),
        .done        (done4),
        .quotient    (quotient4),
        .remainder   (remainder4),
        .div_by_zero (div_by_zero4)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Latency counts clock edges from the accepting edge up to the first one after which done is seen.
    task automatic applyStimulus(input bit sel, input logic [31:0] a, input logic [31:0] b, output int lat);
        if (sel) begin
            dividend4 = a; divisor4 = b; start4 = 1'b1;
        end else begin
            dividend = a; divisor = b; start = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0; start4 = 1'b0;
        lat = 1;
        while (!(sel ? done4 : done) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic runDiv(input bit sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_q, input logic [31:0] exp_r, input logic exp_z,
                          input int exp_lat, input string tag);
        int lat;
        applyStimulus(sel, a, b, lat);
        checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        checkOutput({tag, "_quotient"}, sel ? quotient4 : quotient, exp_q);
        checkOutput({tag, "_remainder"}, sel ? remainder4 : remainder, exp_r);
        checkOutput({tag, "_dbz"}, sel ? div_by_zero4 : div_by_zero, exp_z);
        @(posedge clk); #1;
        checkOutput({tag, "_done_pulse"}, sel ? done4 : done, 1'b0);
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] a, b;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", ready, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_quotient", quotient, 32'h0);
        checkOutput("rst_remainder", remainder, 32'h0);
        checkOutput("rst_dbz", div_by_zero, 1'b0);
        checkOutput("rst_ready4", ready4, 1'b1);
        checkOutput("rst_busy4", busy4, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        runDiv(0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, "div_100_7");
        runDiv(0, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 33, "div_3_10");
        runDiv(0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, "div_max_1");
        runDiv(0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, "div_by_zero");
        runDiv(0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, "div_9_3");

        // Extra starts during COMPUTE and DONE must not be accepted.
        dividend = 32'd20; divisor = 32'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("proto_busy", busy, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        dividend = 32'd50; divisor = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 5;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("proto_latency", 64'(lat), 64'd33);
        checkOutput("proto_quotient", quotient, 32'd3);
        checkOutput("proto_remainder", remainder, 32'd2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("proto_done_start_ready", ready, 1'b1);
        checkOutput("proto_done_start_busy", busy, 1'b0);
        checkOutput("proto_held_quotient", quotient, 32'd3);

        // Abort while computing: back to IDLE, previous results held, no done.
        dividend = 32'd100; divisor = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("abort_ready", ready, 1'b1);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_done", done, 1'b0);
        checkOutput("abort_quotient", quotient, 32'd3);
        checkOutput("abort_remainder", remainder, 32'd2);
        checkOutput("abort_dbz", div_by_zero, 1'b0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        checkOutput("abort_no_done", 64'(seen), 64'd0);

        start = 1'b1; abort = 1'b1; dividend = 32'd8; divisor = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        checkOutput("start_abort_ready", ready, 1'b1);
        checkOutput("start_abort_busy", busy, 1'b0);
        checkOutput("start_abort_done", done, 1'b0);

        // Reset in the middle of COMPUTE.
        dividend = 32'd50; divisor = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midrst_ready", ready, 1'b1);
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_quotient", quotient, 32'h0);
        checkOutput("midrst_remainder", remainder, 32'h0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        checkOutput("midrst_no_done", 64'(seen), 64'd0);
        runDiv(0, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 33, "div_1000_33");

        runDiv(1, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2, 1'b0, 9, "u4_msb_3");

        for (int n = 0; n < 1000; n++) begin
            a = $urandom;
            b = $urandom & 32'h7FFF_FFFF;
            if (b == 32'd0) b = 32'd1;
            runDiv(1, a, b, a / b, a % b, 1'b0, 9, "u4_rand");
            checkOutput("u4_rand_rem_lt_div", 64'(remainder4 < b), 64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
